// File: rtl/aes_axis_block_packer.sv
// rtl/aes_axis_block_packer.sv - packs 32-bit AXI-Stream words into padded 128-bit AES blocks
// Optional AES_PACK_BSWAP_EN: byte-reverse each input word before placement.
module aes_axis_block_packer #(
  parameter int         C_S_AXIS_TDATA_WIDTH = 32,
  parameter int         C_M_AXIS_TDATA_WIDTH = 128,
  parameter logic [7:0] PAD_BYTE             = 8'h00,
  parameter int         CNT_WIDTH            = 16
) (
  input  logic                              s00_axis_aclk,
  input  logic                              s00_axis_aresetn,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
  input  logic                              s00_axis_tvalid,
  input  logic                              s00_axis_tlast,
  output logic                              s00_axis_tready,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
  output logic [C_M_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tkeep,
  output logic                              m00_axis_tlast,
  output logic                              m00_axis_tvalid,
  input  logic                              m00_axis_tready,
  output logic [CNT_WIDTH-1:0]              blk_count
);

  typedef enum logic {FILL, HOLD} state_t;

  state_t      state, state_next;
  logic        running;
  logic [1:0]  wcnt;
  logic [31:0] asm_w [4];
  logic [31:0] cur_w [4];
  logic [31:0] word_in;
  logic [15:0] cur_keep, hold_keep;
  logic        hold_last;
  logic        accept, complete, slot_free;
  logic        load_new, load_held, stash;

`ifdef AES_PACK_BSWAP_EN
  assign word_in = {s00_axis_tdata[7:0], s00_axis_tdata[15:8],
                    s00_axis_tdata[23:16], s00_axis_tdata[31:24]};
`else
  assign word_in = s00_axis_tdata;
`endif

  // running keeps tready low until the first edge after reset release
  assign s00_axis_tready = running && (state == FILL);
  assign accept          = s00_axis_tvalid && s00_axis_tready;
  assign complete        = accept && ((wcnt == 2'd3) || s00_axis_tlast);
  assign slot_free       = !m00_axis_tvalid || m00_axis_tready;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      if (i < int'(wcnt))       cur_w[i] = asm_w[i];
      else if (i == int'(wcnt)) cur_w[i] = word_in;
      else                      cur_w[i] = {4{PAD_BYTE}};
    end
    case (wcnt)
      2'd0:    cur_keep = 16'hF000;
      2'd1:    cur_keep = 16'hFF00;
      2'd2:    cur_keep = 16'hFFF0;
      default: cur_keep = 16'hFFFF;
    endcase
  end

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) state <= FILL;
    else                   state <= state_next;
  end

  always_comb begin
    state_next = state;
    load_new   = 1'b0;
    load_held  = 1'b0;
    stash      = 1'b0;
    case (state)
      FILL: begin
        if (complete) begin
          if (slot_free) load_new = 1'b1;
          else begin
            stash      = 1'b1;
            state_next = HOLD;
          end
        end
      end
      HOLD: begin
        if (slot_free) begin
          load_held  = 1'b1;
          state_next = FILL;
        end
      end
      default: state_next = FILL;
    endcase
  end

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      running         <= 1'b0;
      wcnt            <= 2'd0;
      for (int k = 0; k < 4; k++) asm_w[k] <= 32'd0;
      hold_keep       <= 16'd0;
      hold_last       <= 1'b0;
      m00_axis_tdata  <= '0;
      m00_axis_tkeep  <= '0;
      m00_axis_tlast  <= 1'b0;
      m00_axis_tvalid <= 1'b0;
      blk_count       <= '0;
    end else begin
      running <= 1'b1;
      if (accept) begin
        if (complete) wcnt <= 2'd0;
        else begin
          wcnt        <= wcnt + 2'd1;
          asm_w[wcnt] <= word_in;
        end
      end
      // a block that cannot reach the output waits in the assembly slots
      if (stash) begin
        for (int k = 0; k < 4; k++) asm_w[k] <= cur_w[k];
        hold_keep <= cur_keep;
        hold_last <= s00_axis_tlast;
      end
      if (load_new) begin
        m00_axis_tdata <= {cur_w[0], cur_w[1], cur_w[2], cur_w[3]};
        m00_axis_tkeep <= cur_keep;
        m00_axis_tlast <= s00_axis_tlast;
      end else if (load_held) begin
        m00_axis_tdata <= {asm_w[0], asm_w[1], asm_w[2], asm_w[3]};
        m00_axis_tkeep <= hold_keep;
        m00_axis_tlast <= hold_last;
      end
      if (load_new || load_held) m00_axis_tvalid <= 1'b1;
      else if (m00_axis_tready)  m00_axis_tvalid <= 1'b0;
      if (m00_axis_tvalid && m00_axis_tready) blk_count <= blk_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_aes_axis_block_packer.sv
// tb/tb_aes_axis_block_packer.sv - randomized self-checking bench for aes_axis_block_packer
// Expected blocks come from a queue model of word grouping, padding and a two-deep output capacity.
module tb_aes_axis_block_packer;

  localparam logic [7:0] PAD = 8'h00;

  typedef struct packed {
    logic [127:0] data;
    logic [15:0]  keep;
    logic         last;
  } blk_t;

  logic         clk;
  logic         rst_n;
  logic [31:0]  s_tdata;
  logic         s_tvalid;
  logic         s_tlast;
  logic         s_tready;
  logic [127:0] m_tdata;
  logic [15:0]  m_tkeep;
  logic         m_tlast;
  logic         m_tvalid;
  logic         m_tready;
  logic [15:0]  blk_count;

  int tests = 0;
  int fails = 0;

  blk_t        exp_q[$];
  blk_t        log_q[$];
  logic [31:0] cur_words[$];
  logic [15:0] exp_cnt = '0;
  bit          running = 0;
  bit          rand_mode = 0;
  logic        m_cmd = 1'b1;

  aes_axis_block_packer dut (
    .s00_axis_aclk   (clk),
    .s00_axis_aresetn(rst_n),
    .s00_axis_tdata  (s_tdata),
    .s00_axis_tvalid (s_tvalid),
    .s00_axis_tlast  (s_tlast),
    .s00_axis_tready (s_tready),
    .m00_axis_tdata  (m_tdata),
    .m00_axis_tkeep  (m_tkeep),
    .m00_axis_tlast  (m_tlast),
    .m00_axis_tvalid (m_tvalid),
    .m00_axis_tready (m_tready),
    .blk_count       (blk_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    m_tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      m_tready = rand_mode ? ($urandom_range(0, 3) != 0) : m_cmd;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] place(input logic [31:0] w);
`ifdef AES_PACK_BSWAP_EN
    place = {<<8{w}};
`else
    place = w;
`endif
  endfunction

  function automatic blk_t mk_block(input logic [127:0] raw, input int n, input logic last);
    blk_t b;
    b.data = raw;
    for (int i = n; i < 4; i++) b.data[127-32*i -: 32] = {4{PAD}};
    b.keep = 16'hFFFF << (4 * (4 - n));
    b.last = last;
    return b;
  endfunction

  // Model: words group into blocks of up to four; at most two finished blocks
  // (output register plus one held) may be outstanding before input stalls.
  always @(negedge clk) begin : cmp
    bit           exp_rdy;
    bit           exp_vld;
    int           n;
    logic [127:0] raw;
    blk_t         b;
    if (!rst_n) begin
      chk("rst_s_tready", 128'(s_tready), 128'(0));
      chk("rst_m_tvalid", 128'(m_tvalid), 128'(0));
      chk("rst_m_tdata", m_tdata, 128'(0));
      chk("rst_m_tkeep", 128'(m_tkeep), 128'(0));
      chk("rst_m_tlast", 128'(m_tlast), 128'(0));
      chk("rst_blk_count", 128'(blk_count), 128'(0));
      exp_q.delete();
      cur_words.delete();
      exp_cnt = '0;
      running = 0;
    end else begin
      exp_rdy = running && (exp_q.size() < 2);
      exp_vld = (exp_q.size() != 0);
      chk("s_tready", 128'(s_tready), 128'(exp_rdy));
      chk("m_tvalid", 128'(m_tvalid), 128'(exp_vld));
      if (exp_vld) begin
        chk("m_tdata", m_tdata, exp_q[0].data);
        chk("m_tkeep", 128'(m_tkeep), 128'(exp_q[0].keep));
        chk("m_tlast", 128'(m_tlast), 128'(exp_q[0].last));
      end
      chk("blk_count", 128'(blk_count), 128'(exp_cnt));
      if (m_tvalid && m_tready) begin
        b.data = m_tdata;
        b.keep = m_tkeep;
        b.last = m_tlast;
        log_q.push_back(b);
      end
      if (exp_vld && m_tready) begin
        void'(exp_q.pop_front());
        exp_cnt = exp_cnt + 16'd1;
      end
      if (exp_rdy && s_tvalid) begin
        cur_words.push_back(place(s_tdata));
        if (cur_words.size() == 4 || s_tlast) begin
          n = cur_words.size();
          raw = '0;
          for (int i = 0; i < n; i++) raw[127-32*i -: 32] = cur_words[i];
          exp_q.push_back(mk_block(raw, n, s_tlast));
          cur_words.delete();
        end
      end
      running = 1;
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_word(input logic [31:0] d, input logic l);
    int guard;
    guard    = 0;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = l;
    forever begin
      @(negedge clk);
      if (s_tready) begin
        @(posedge clk);
        #1;
        break;
      end
      @(posedge clk);
      #1;
      guard++;
      if (guard > 300) begin
        tests++;
        fails++;
        $display("FAIL push_timeout: word %h not accepted after %0d cycles", d, guard);
        break;
      end
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 400) begin
      cycles(1);
      g++;
    end
    cycles(2);
  endtask

  initial begin
    blk_t pin;
    int   n0;
    rst_n    = 1'b0;
    s_tdata  = '0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;

    pin = mk_block({32'hDEADBEEF, 32'h01020304, 64'h0}, 2, 1'b1);
    chk("model_pad_data", pin.data, 128'hDEADBEEF_01020304_00000000_00000000);
    chk("model_keep2", 128'(pin.keep), 128'(16'hFF00));
    pin = mk_block(128'h11111111_22222222_33333333_44444444, 1, 1'b0);
    chk("model_keep1", 128'(pin.keep), 128'(16'hF000));
    chk("model_pad1", pin.data, 128'h11111111_00000000_00000000_00000000);
`ifdef AES_PACK_BSWAP_EN
    chk("model_place", 128'(place(32'h00112233)), 128'(32'h33221100));
`else
    chk("model_place", 128'(place(32'h00112233)), 128'(32'h00112233));
`endif

    cycles(3);
    rst_n = 1'b1;

    push_word(32'h00112233, 1'b0);
    push_word(32'h44556677, 1'b0);
    push_word(32'h8899AABB, 1'b0);
    push_word(32'hCCDDEEFF, 1'b1);
    cycles(3);
    @(negedge clk);
    chk("t1_log_size", 128'(log_q.size()), 128'(1));
`ifdef AES_PACK_BSWAP_EN
    chk("t1_data", log_q[0].data, 128'h33221100_77665544_BBAA9988_FFEEDDCC);
`else
    chk("t1_data", log_q[0].data, 128'h00112233_44556677_8899AABB_CCDDEEFF);
`endif
    chk("t1_keep", 128'(log_q[0].keep), 128'(16'hFFFF));
    chk("t1_last", 128'(log_q[0].last), 128'(1));
    chk("t1_blk_count", 128'(blk_count), 128'(1));
    @(posedge clk);
    #1;

    push_word(32'hDEADBEEF, 1'b0);
    push_word(32'h01020304, 1'b1);
    cycles(3);
    @(negedge clk);
`ifdef AES_PACK_BSWAP_EN
    chk("t2_data", log_q[1].data, 128'hEFBEADDE_04030201_00000000_00000000);
`else
    chk("t2_data", log_q[1].data, 128'hDEADBEEF_01020304_00000000_00000000);
`endif
    chk("t2_keep", 128'(log_q[1].keep), 128'(16'hFF00));
    chk("t2_last", 128'(log_q[1].last), 128'(1));
    @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) push_word($urandom, i == 11);
    cycles(3);
    @(negedge clk);
    chk("t3_log_size", 128'(log_q.size()), 128'(5));
    chk("t3_blk_count", 128'(blk_count), 128'(5));
    @(posedge clk);
    #1;

    m_cmd = 1'b0;
    cycles(2);
    for (int i = 0; i < 8; i++) push_word(32'hA0A00000 + 32'(i), 1'b0);
    @(negedge clk);
    chk("t4_hold_tready", 128'(s_tready), 128'(0));
    chk("t4_held_data", m_tdata, {place(32'hA0A00000), place(32'hA0A00001),
                                  place(32'hA0A00002), place(32'hA0A00003)});
    @(posedge clk);
    #1;
    cycles(11);
    @(negedge clk);
    chk("t4_stable_data", m_tdata, {place(32'hA0A00000), place(32'hA0A00001),
                                    place(32'hA0A00002), place(32'hA0A00003)});
    @(posedge clk);
    #1;
    m_cmd = 1'b1;
    wait_drain();
    @(negedge clk);
    chk("t4_log_size", 128'(log_q.size()), 128'(7));
    chk("t4_blk_a", log_q[5].data, {place(32'hA0A00000), place(32'hA0A00001),
                                    place(32'hA0A00002), place(32'hA0A00003)});
    chk("t4_blk_b", log_q[6].data, {place(32'hA0A00004), place(32'hA0A00005),
                                    place(32'hA0A00006), place(32'hA0A00007)});
    chk("t4_blk_count", 128'(blk_count), 128'(7));
    @(posedge clk);
    #1;

    push_word(32'hBAD00000, 1'b0);
    push_word(32'hBAD00001, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t5_rst_tvalid", 128'(m_tvalid), 128'(0));
    chk("t5_rst_blk_count", 128'(blk_count), 128'(0));
    @(posedge clk);
    #1;
    cycles(1);
    rst_n = 1'b1;
    n0 = log_q.size();
    for (int i = 0; i < 4; i++) push_word(32'h55550000 + 32'(i), i == 3);
    wait_drain();
    @(negedge clk);
    chk("t5_log_size", 128'(log_q.size()), 128'(n0 + 1));
    chk("t5_data", log_q[n0].data, {place(32'h55550000), place(32'h55550001),
                                    place(32'h55550002), place(32'h55550003)});
    chk("t5_last", 128'(log_q[n0].last), 128'(1));
    chk("t5_blk_count", 128'(blk_count), 128'(1));
    @(posedge clk);
    #1;

    rand_mode = 1;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 3) == 0) cycles(1);
      push_word($urandom, $urandom_range(0, 4) == 0);
    end
    rand_mode = 0;
    m_cmd = 1'b1;
    wait_drain();
    @(negedge clk);
    chk("final_pending", 128'(exp_q.size()), 128'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
